input_setup: RTL

//   Takes one 2x2 activation tile (four words) from the unified buffer's read port and

---
 rtl/input_setup.sv | 124 ++++++++++++
 1 files changed

// File: rtl/input_setup.sv
//------------------------------------------------------------------------------
// input_setup
//   Feeds one 2x2 activation tile from the unified buffer into the two west-edge
//   rows of a 2x2 systolic array with a one-cycle diagonal skew between rows.
//   Row 0 receives in_00 then in_01; row 1 receives in_10 then in_11 one cycle
//   later. A valid/ready handshake lets tiles stream back to back, one tile
//   every three cycles.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module input_setup #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,        // asynchronous, active-low
   input  logic              tile_valid,
   output logic              tile_ready,
   input  logic [DATA_W-1:0] in_00,
   input  logic [DATA_W-1:0] in_01,
   input  logic [DATA_W-1:0] in_10,
   input  logic [DATA_W-1:0] in_11,
   input  logic              clear,
   output logic [DATA_W-1:0] a_in1,
   output logic [DATA_W-1:0] a_in2,
   output logic              valid1,
   output logic              valid2,
   output logic              busy,
   output logic              done,
   output logic [7:0]        tile_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      S0   = 2'd1,
      S1   = 2'd2,
      S2   = 2'd3
   } state_t;

   state_t state;

   // in_00 is driven onto a_in1 directly at the accept edge, so only the
   // three words used in later skew cycles need holding.
   logic [DATA_W-1:0] h01;
   logic [DATA_W-1:0] h10;
   logic [DATA_W-1:0] h11;

   logic accept;

   // A new tile can be taken when idle, or in the last skew cycle so that
   // consecutive tiles leave no bubble. clear always wins over a pending tile.
   assign tile_ready = (state == IDLE) || (state == S2);
   assign accept     = tile_valid & tile_ready & ~clear;
   assign busy       = (state != IDLE);

   // Sequencer: advances through the skew cycles and registers the row outputs.
   // a_in2 has its own register, so the old h11 stays on row 1 during S2 even
   // though the hold registers are reloaded with the next tile at that edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         a_in1  <= '0;
         a_in2  <= '0;
         valid1 <= 1'b0;
         valid2 <= 1'b0;
         done   <= 1'b0;
      end else begin
         a_in1  <= '0;
         a_in2  <= '0;
         valid1 <= 1'b0;
         valid2 <= 1'b0;
         done   <= 1'b0;
         if (clear) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE, S2: begin
                  if (accept) begin
                     state  <= S0;
                     a_in1  <= in_00;
                     valid1 <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
               S0: begin
                  state  <= S1;
                  a_in1  <= h01;
                  valid1 <= 1'b1;
                  a_in2  <= h10;
                  valid2 <= 1'b1;
               end
               S1: begin
                  state  <= S2;
                  a_in2  <= h11;
                  valid2 <= 1'b1;
                  done   <= 1'b1;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   // Tile capture and accepted-tile counter; both untouched by clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h01        <= '0;
         h10        <= '0;
         h11        <= '0;
         tile_count <= 8'd0;
      end else if (accept) begin
         h01        <= in_01;
         h10        <= in_10;
         h11        <= in_11;
         tile_count <= tile_count + 8'd1;
      end
   end

endmodule

`default_nettype wire
